// File: rtl/video_frame_capture.sv
// Captures one downscaled frame of the pixel stream into an RGB332 framebuffer
// with a registered read port. Define CAPTURE_CRC_EN to add the o_crc output.
module video_frame_capture #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int SCALE_SHIFT = 3,
  parameter int ADDR_W      = 13
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [9:0]        i_hpos,
  input  logic [9:0]        i_vpos,
  input  logic              i_visible,
  input  logic [7:0]        i_r,
  input  logic [7:0]        i_g,
  input  logic [7:0]        i_b,
  input  logic              i_arm,
  output logic              o_busy,
  output logic              o_done,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [7:0]        o_rd_data
`ifdef CAPTURE_CRC_EN
  ,
  output logic [15:0]       o_crc
`endif
);

  localparam int FB_W  = H_ACTIVE >> SCALE_SHIFT;
  localparam int FB_H  = V_ACTIVE >> SCALE_SHIFT;
  localparam int DEPTH = FB_W * FB_H;
  localparam int STEP  = 1 << SCALE_SHIFT;

  localparam logic [9:0]        H_LIMIT  = 10'(H_ACTIVE);
  localparam logic [9:0]        V_LIMIT  = 10'(V_ACTIVE);
  localparam logic [9:0]        LOW_MASK = 10'(STEP - 1);
  localparam logic [9:0]        LAST_H   = 10'(H_ACTIVE - STEP);
  localparam logic [9:0]        LAST_V   = 10'(V_ACTIVE - STEP);
  localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_CAPT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [7:0]        rd_data_q, rd_data_d;
  logic [7:0]        mem [DEPTH];

  logic              in_range, sample_pt, frame_start, last_pt, arm_ok;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_ptr;
  logic [7:0]        wr_data;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= S_IDLE;
      wr_addr_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_data_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      wr_addr_q <= wr_addr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rd_data_q <= rd_data_d;
    end
  end

  always_comb begin
    in_range    = (i_hpos < H_LIMIT) && (i_vpos < V_LIMIT);
    sample_pt   = i_visible && in_range &&
                  ((i_hpos & LOW_MASK) == 10'd0) && ((i_vpos & LOW_MASK) == 10'd0);
    frame_start = i_visible && (i_hpos == 10'd0) && (i_vpos == 10'd0);
    last_pt     = (i_hpos == LAST_H) && (i_vpos == LAST_V);
    arm_ok      = i_arm && ((state_q == S_IDLE) || (state_q == S_DONE));
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (i_arm) state_d = S_ARMED; else state_d = S_IDLE;
      S_ARMED: if (frame_start) state_d = S_CAPT; else state_d = S_ARMED;
      S_CAPT:  if (wr_en && last_pt) state_d = S_DONE; else state_d = S_CAPT;
      S_DONE:  if (i_arm) state_d = S_ARMED; else state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // The frame-start pixel is written at address 0 on the cycle ARMED is left.
  always_comb begin
    wr_en   = sample_pt && ((state_q == S_CAPT) || ((state_q == S_ARMED) && frame_start));
    wr_ptr  = (state_q == S_ARMED) ? '0 : wr_addr_q;
    wr_data = {i_r[7:5], i_g[7:5], i_b[7:6]};
    if (wr_en) begin
      wr_addr_d = wr_ptr + ADDR_W'(1);
    end else begin
      wr_addr_d = wr_addr_q;
    end
    if (i_rd_addr < DEPTH_A) begin
      rd_data_d = mem[i_rd_addr];
    end else begin
      rd_data_d = 8'd0;
    end
  end

  always_comb begin
    busy_d = (state_d == S_ARMED) || (state_d == S_CAPT);
    done_d = (state_d == S_DONE);
  end

  // Framebuffer storage is never cleared; reset only blocks the write.
  always_ff @(posedge i_clk) begin
    if (wr_en && !i_reset) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  assign o_busy    = busy_q;
  assign o_done    = done_q;
  assign o_rd_data = rd_data_q;

`ifdef CAPTURE_CRC_EN
  logic [15:0] crc_q, crc_d;

  function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in, input logic [7:0] data);
    logic [15:0] c;
    c = crc_in ^ {data, 8'h00};
    for (int i = 0; i < 8; i++) begin
      if (c[15]) begin
        c = {c[14:0], 1'b0} ^ 16'h1021;
      end else begin
        c = {c[14:0], 1'b0};
      end
    end
    return c;
  endfunction

  always_comb begin
    if (arm_ok) begin
      crc_d = 16'hFFFF;
    end else if (wr_en) begin
      crc_d = crc16_byte(crc_q, wr_data);
    end else begin
      crc_d = crc_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      crc_q <= 16'hFFFF;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign o_crc = crc_q;
`else
  logic unused_arm_ok;
  assign unused_arm_ok = arm_ok;
`endif

endmodule
